// File: rtl/tnn_neuron_driver.sv
// Ternary-neuron front end: accumulates a/b/c saturating counts per frame and returns the comparator decision.
// Optional exact-reference mismatch flag is built when TNN_DRV_EXACT_CHECK_EN is defined.
module tnn_neuron_driver #(
  parameter int N_IN = 6,
  parameter int CW   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_x,
  input  logic [1:0]    in_w,
  input  logic          in_last,
  output logic [CW-1:0] cmp_a,
  output logic [CW-1:0] cmp_b,
  output logic [CW-1:0] cmp_c,
  input  logic          cmp_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_bit,
  output logic          out_sat,
  output logic          out_err
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [IW-1:0] IDX_LAST = IW'(N_IN - 1);

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [IW-1:0] idx_r;
  logic [CW-1:0] cnt_a_r, cnt_b_r, cnt_c_r;
  logic [CW-1:0] cnt_a_s, cnt_b_s, cnt_c_s;
  logic          sat_r, sat_s;
  logic          bit_r;
  logic          beat_s, clear_s, pos_s, neg_s;
  logic [CW:0]   inc_a_s, inc_b_s, inc_c_s;

  // Returns {at_max, next_value}; the count holds at max instead of wrapping.
  function automatic logic [CW:0] sat_inc(input logic [CW-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = {1'b1, v};
    end else begin
      sat_inc = {1'b0, v + {{(CW-1){1'b0}}, 1'b1}};
    end
  endfunction

  // Next-state decode and beat/clear qualification.
  always_comb begin
    state_s = state_r;
    beat_s  = 1'b0;
    clear_s = 1'b0;
    case (state_r)
      ACC: begin
        beat_s = in_valid & in_ready;
        if (beat_s && (in_last || (idx_r == IDX_LAST))) begin
          state_s = EVAL;
        end else begin
          state_s = ACC;
        end
      end
      EVAL: state_s = HOLD;
      HOLD: begin
        if (out_ready) begin
          state_s = ACC;
          clear_s = 1'b1;
        end else begin
          state_s = HOLD;
        end
      end
      default: state_s = ACC;
    endcase
  end

  // Saturating counter update for the current beat; reserved weight 2'b10 falls through as zero.
  always_comb begin
    pos_s   = beat_s & in_x & (in_w == 2'b01);
    neg_s   = beat_s & in_x & (in_w == 2'b11);
    inc_a_s = sat_inc(cnt_a_r);
    inc_b_s = sat_inc(cnt_b_r);
    inc_c_s = sat_inc(cnt_c_r);
    cnt_a_s = cnt_a_r;
    cnt_b_s = cnt_b_r;
    cnt_c_s = cnt_c_r;
    sat_s   = sat_r;
    if (pos_s && !idx_r[0]) begin
      cnt_a_s = inc_a_s[CW-1:0];
      sat_s   = sat_r | inc_a_s[CW];
    end else if (pos_s) begin
      cnt_b_s = inc_b_s[CW-1:0];
      sat_s   = sat_r | inc_b_s[CW];
    end else if (neg_s) begin
      cnt_c_s = inc_c_s[CW-1:0];
      sat_s   = sat_r | inc_c_s[CW];
    end else begin
      sat_s   = sat_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ACC;
    else     state_r <= state_s;
  end

  // Counters, beat index and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (rst || clear_s) begin
      idx_r   <= {IW{1'b0}};
      cnt_a_r <= {CW{1'b0}};
      cnt_b_r <= {CW{1'b0}};
      cnt_c_r <= {CW{1'b0}};
      sat_r   <= 1'b0;
    end else if (beat_s) begin
      idx_r   <= idx_r + IW'(1);
      cnt_a_r <= cnt_a_s;
      cnt_b_r <= cnt_b_s;
      cnt_c_r <= cnt_c_s;
      sat_r   <= sat_s;
    end
  end

  // Decision capture at the end of EVAL, held until the next evaluation.
  always_ff @(posedge clk) begin
    if (rst)                  bit_r <= 1'b0;
    else if (state_r == EVAL) bit_r <= cmp_out;
  end

`ifdef TNN_DRV_EXACT_CHECK_EN
  logic err_r;

  function automatic logic exact_gt(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                    input logic [CW-1:0] c);
    exact_gt = (({1'b0, a} + {1'b0, b}) > {1'b0, c});
  endfunction

  // Exact-vs-approximate mismatch captured alongside the decision.
  always_ff @(posedge clk) begin
    if (rst)                  err_r <= 1'b0;
    else if (state_r == EVAL) err_r <= exact_gt(cnt_a_r, cnt_b_r, cnt_c_r) ^ cmp_out;
  end

  assign out_err = err_r;
`else
  assign out_err = 1'b0;
`endif

  assign in_ready  = (state_r == ACC) & ~rst;
  assign out_valid = (state_r == HOLD);
  assign out_bit   = bit_r;
  assign out_sat   = sat_r;
  assign cmp_a     = cnt_a_r;
  assign cmp_b     = cnt_b_r;
  assign cmp_c     = cnt_c_r;

endmodule

// File: tb/tb_tnn_neuron_driver.sv
// Directed bench for tnn_neuron_driver: one N_IN=6 instance for frame behaviour and one N_IN=64 instance for saturation.
module tb_tnn_neuron_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       force0;
  int         n_checks = 0;
  int         n_fail   = 0;

  logic       in_valid, in_ready, in_x, in_last, cmp_out, out_valid, out_ready;
  logic [1:0] in_w;
  logic [2:0] cmp_a, cmp_b, cmp_c;
  logic       out_bit, out_sat, out_err;

  logic       v64, rdy64, x64, l64, cmp64, ov64, or64, bit64, sat64, err64;
  logic [1:0] w64;
  logic [2:0] a64, b64, c64;

  always #5 clk = ~clk;

  // Exact comparator models; force0 emulates a stuck-low approximate comparator.
  assign cmp_out = force0 ? 1'b0 : (({1'b0, cmp_a} + {1'b0, cmp_b}) > {1'b0, cmp_c});
  assign cmp64   = ({1'b0, a64} + {1'b0, b64}) > {1'b0, c64};

  tnn_neuron_driver #(.N_IN(6), .CW(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .in_w(in_w), .in_last(in_last), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_c(cmp_c),
    .cmp_out(cmp_out), .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_sat(out_sat), .out_err(out_err)
  );

  tnn_neuron_driver #(.N_IN(64), .CW(3)) dut64 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(rdy64), .in_x(x64),
    .in_w(w64), .in_last(l64), .cmp_a(a64), .cmp_b(b64), .cmp_c(c64),
    .cmp_out(cmp64), .out_valid(ov64), .out_ready(or64), .out_bit(bit64),
    .out_sat(sat64), .out_err(err64)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic x, input logic [1:0] w, input logic last);
    @(negedge clk);
    in_valid = 1'b1; in_x = x; in_w = w; in_last = last;
    @(posedge clk);
  endtask

  // Six-beat frame ended by the index limit: expects a=2 b=1 c=1.
  task automatic frame1(input string tag, input logic exp_bit, input logic exp_err);
    send(1'b1, 2'b01, 1'b0);
    send(1'b1, 2'b01, 1'b0);
    send(1'b1, 2'b11, 1'b0);
    send(1'b0, 2'b11, 1'b0);
    send(1'b1, 2'b01, 1'b0);
    send(1'b1, 2'b00, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_eval_rdy"}, 8'(in_ready), 8'd0);
    chk({tag, "_eval_ov"}, 8'(out_valid), 8'd0);
    chk({tag, "_a"}, 8'(cmp_a), 8'd2);
    chk({tag, "_b"}, 8'(cmp_b), 8'd1);
    chk({tag, "_c"}, 8'(cmp_c), 8'd1);
    @(negedge clk);
    chk({tag, "_ov"}, 8'(out_valid), 8'd1);
    chk({tag, "_bit"}, 8'(out_bit), 8'(exp_bit));
    chk({tag, "_sat"}, 8'(out_sat), 8'd0);
    chk({tag, "_err"}, 8'(out_err), 8'(exp_err));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ov_clr"}, 8'(out_valid), 8'd0);
    chk({tag, "_rdy_back"}, 8'(in_ready), 8'd1);
    chk({tag, "_a_clr"}, 8'(cmp_a), 8'd0);
  endtask

  initial begin
    rst = 1'b1; force0 = 1'b0;
    in_valid = 1'b0; in_x = 1'b0; in_w = 2'b00; in_last = 1'b0; out_ready = 1'b0;
    v64 = 1'b0; x64 = 1'b0; w64 = 2'b00; l64 = 1'b0; or64 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", 8'(in_ready), 8'd0);
    chk("rst_ov", 8'(out_valid), 8'd0);
    chk("rst_bit", 8'(out_bit), 8'd0);
    chk("rst_sat", 8'(out_sat), 8'd0);
    chk("rst_err", 8'(out_err), 8'd0);
    chk("rst_abc", 8'({cmp_a, cmp_b, cmp_c}), 8'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", 8'(in_ready), 8'd1);

    frame1("f1", 1'b1, 1'b0);

    // Three negative beats ended by in_last.
    send(1'b1, 2'b11, 1'b0);
    send(1'b1, 2'b11, 1'b0);
    send(1'b1, 2'b11, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("f2_eval_rdy", 8'(in_ready), 8'd0);
    chk("f2_abc", 8'({cmp_a, cmp_b, cmp_c}), 8'({3'd0, 3'd0, 3'd3}));
    @(negedge clk);
    chk("f2_hold_rdy", 8'(in_ready), 8'd0);
    chk("f2_ov", 8'(out_valid), 8'd1);
    chk("f2_bit", 8'(out_bit), 8'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("f2_rdy_back", 8'(in_ready), 8'd1);
    chk("f2_ov_clr", 8'(out_valid), 8'd0);

    // Reserved weight counts as zero; HOLD back-pressure with in_valid ignored.
    send(1'b1, 2'b01, 1'b0);
    send(1'b1, 2'b10, 1'b0);
    send(1'b1, 2'b01, 1'b1);
    @(negedge clk);
    in_last = 1'b0; in_w = 2'b01;
    chk("f3_abc", 8'({cmp_a, cmp_b, cmp_c}), 8'({3'd2, 3'd0, 3'd0}));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("f3_hold_ov", 8'(out_valid), 8'd1);
      chk("f3_hold_bit", 8'(out_bit), 8'd1);
      chk("f3_hold_rdy", 8'(in_ready), 8'd0);
      chk("f3_hold_abc", 8'({cmp_a, cmp_b, cmp_c}), 8'({3'd2, 3'd0, 3'd0}));
    end
    chk("f3_sat", 8'(out_sat), 8'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("f3_abc_clr", 8'({cmp_a, cmp_b, cmp_c}), 8'd0);
    chk("f3_ov_clr", 8'(out_valid), 8'd0);

    // Reset after two beats discards the partial frame.
    send(1'b1, 2'b01, 1'b0);
    send(1'b1, 2'b11, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rdy", 8'(in_ready), 8'd0);
    chk("mid_rst_ov", 8'(out_valid), 8'd0);
    chk("mid_rst_abc", 8'({cmp_a, cmp_b, cmp_c}), 8'd0);
    chk("mid_rst_bit", 8'(out_bit), 8'd0);
    rst = 1'b0;
    frame1("f4", 1'b1, 1'b0);

    // Stuck-low comparator: decision follows cmp_out, mismatch flagged only with the reference built.
    force0 = 1'b1;
`ifdef TNN_DRV_EXACT_CHECK_EN
    frame1("f5", 1'b0, 1'b1);
`else
    frame1("f5", 1'b0, 1'b0);
`endif
    force0 = 1'b0;

    // Twenty negative beats on the 64-input instance: c saturates at 7.
    chk("s_rdy", 8'(rdy64), 8'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      v64 = 1'b1; x64 = 1'b1; w64 = 2'b11; l64 = (i == 19);
      if (i == 7) begin
        chk("s_c_at_7", 8'(c64), 8'd7);
        chk("s_sat_pre", 8'(sat64), 8'd0);
      end
      @(posedge clk);
    end
    @(negedge clk);
    v64 = 1'b0; l64 = 1'b0;
    chk("s_c", 8'(c64), 8'd7);
    chk("s_eval_rdy", 8'(rdy64), 8'd0);
    @(negedge clk);
    chk("s_ov", 8'(ov64), 8'd1);
    chk("s_sat", 8'(sat64), 8'd1);
    chk("s_bit", 8'(bit64), 8'd0);
    chk("s_err", 8'(err64), 8'd0);
    or64 = 1'b1;
    @(negedge clk);
    or64 = 1'b0;
    chk("s_sat_clr", 8'(sat64), 8'd0);
    chk("s_c_clr", 8'(c64), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
